// File: rtl/bfu_dif_pre.sv
// bfu_dif_pre: front end of the radix-2 DIF butterfly.
// For each accepted pair (a, b) it forms a+b and a-b at full precision. It
// issues the twiddle ROM read for the pair's k index. It presents a-b to the
// complex multiplier A port on the same cycle the ROM data returns. It delays
// a+b by the multiplier latency so that the sum leaves together with the
// product.
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   in_valid, frame_start   input pair valid; frame_start marks k=0
//   a_r, a_i, b_r, b_i      signed input points, DWIDTH bits
//   tw_rd_en, tw_addr       twiddle ROM read strobe / address (1-cycle ROM)
//   mult_ar, mult_ai        a-b to multiplier, DWIDTH+1 bits
//   mult_valid              mult_a* valid, aligned with ROM data
//   sum_r, sum_i            a+b, DWIDTH+1 bits, aligned with product
//   sum_valid, frame_last   sum valid; last sample (k=NPTS/2-1) of a frame
module bfu_dif_pre #(
  parameter int unsigned DWIDTH      = 16,
  parameter int unsigned NPTS        = 16,
  parameter int unsigned LOG2_STRIDE = 0,
  parameter int unsigned MULT_LAT    = 6,
  localparam int unsigned TWAW       = $clog2(NPTS) - 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic                     frame_start,
  input  logic signed [DWIDTH-1:0] a_r,
  input  logic signed [DWIDTH-1:0] a_i,
  input  logic signed [DWIDTH-1:0] b_r,
  input  logic signed [DWIDTH-1:0] b_i,
  output logic                     tw_rd_en,
  output logic [TWAW-1:0]          tw_addr,
  output logic signed [DWIDTH:0]   mult_ar,
  output logic signed [DWIDTH:0]   mult_ai,
  output logic                     mult_valid,
  output logic signed [DWIDTH:0]   sum_r,
  output logic signed [DWIDTH:0]   sum_i,
  output logic                     sum_valid,
  output logic                     frame_last
);

  localparam int unsigned XW = DWIDTH + 1;
  localparam int unsigned KW = TWAW;
  localparam logic [KW-1:0] K_LAST = KW'(NPTS / 2 - 1);

  // One entry of the sum delay line.
  typedef struct packed {
    logic                 valid;
    logic                 last;
    logic signed [XW-1:0] re;
    logic signed [XW-1:0] im;
  } sum_t;

  logic [KW-1:0]        k;
  logic [KW-1:0]        k_use;
  logic                 k_is_last;
  logic [TWAW-1:0]      tw_next;
  logic signed [XW-1:0] add_r, add_i, sub_r, sub_i;

  logic                 s1_valid;
  logic                 s1_last;
  logic signed [XW-1:0] s1_sum_r, s1_sum_i;
  logic signed [XW-1:0] s1_diff_r, s1_diff_i;

  sum_t                 dl [MULT_LAT+1];

  // Index for the current sample; a qualified frame_start forces k=0.
  always_comb begin
    k_use     = k;
    if (frame_start) k_use = '0;
    k_is_last = (k_use == K_LAST);
    tw_next   = TWAW'(32'(k_use) << LOG2_STRIDE);
  end

  // Full-precision add/subtract on sign-extended operands.
  always_comb begin
    add_r = XW'(a_r) + XW'(b_r);
    add_i = XW'(a_i) + XW'(b_i);
    sub_r = XW'(a_r) - XW'(b_r);
    sub_i = XW'(a_i) - XW'(b_i);
  end

  // Stage 1: register sum/diff, issue ROM read, advance k.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k         <= '0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum_r  <= '0;
      s1_sum_i  <= '0;
      s1_diff_r <= '0;
      s1_diff_i <= '0;
      tw_rd_en  <= 1'b0;
      tw_addr   <= '0;
    end else begin
      s1_valid <= in_valid;
      tw_rd_en <= in_valid;
      if (in_valid) begin
        s1_last   <= k_is_last;
        s1_sum_r  <= add_r;
        s1_sum_i  <= add_i;
        s1_diff_r <= sub_r;
        s1_diff_i <= sub_i;
        tw_addr   <= tw_next;
        k         <= k_is_last ? '0 : k_use + KW'(1);
      end
    end
  end

  // Stage 2: difference to the multiplier, aligned with ROM data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mult_valid <= 1'b0;
      mult_ar    <= '0;
      mult_ai    <= '0;
    end else begin
      mult_valid <= s1_valid;
      if (s1_valid) begin
        mult_ar <= s1_diff_r;
        mult_ai <= s1_diff_i;
      end
    end
  end

  // Sum delay line: entry 0 lines up with the multiplier inputs, entry
  // MULT_LAT with the product. With MULT_LAT=0 the sum leaves with mult_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= int'(MULT_LAT); j++) dl[j] <= '0;
    end else begin
      dl[0].valid <= s1_valid;
      dl[0].last  <= s1_valid & s1_last;
      if (s1_valid) begin
        dl[0].re <= s1_sum_r;
        dl[0].im <= s1_sum_i;
      end
      for (int j = 1; j <= int'(MULT_LAT); j++) begin
        dl[j].valid <= dl[j-1].valid;
        dl[j].last  <= dl[j-1].last;
        if (dl[j-1].valid) begin
          dl[j].re <= dl[j-1].re;
          dl[j].im <= dl[j-1].im;
        end
      end
    end
  end

  assign sum_r      = dl[MULT_LAT].re;
  assign sum_i      = dl[MULT_LAT].im;
  assign sum_valid  = dl[MULT_LAT].valid;
  assign frame_last = dl[MULT_LAT].last;

endmodule

// File: tb/tb_bfu_dif_pre.sv
// tb_bfu_dif_pre: directed self-checking bench for bfu_dif_pre
// (DWIDTH=16, NPTS=16, LOG2_STRIDE=1, MULT_LAT=6).
module tb_bfu_dif_pre;

  logic               clk;
  logic               reset_n;
  logic               in_valid;
  logic               frame_start;
  logic signed [15:0] a_r, a_i, b_r, b_i;
  logic               tw_rd_en;
  logic [2:0]         tw_addr;
  logic signed [16:0] mult_ar, mult_ai;
  logic               mult_valid;
  logic signed [16:0] sum_r, sum_i;
  logic               sum_valid;
  logic               frame_last;

  int checks = 0;
  int errors = 0;

  // One input vector with its hand-computed expectations.
  typedef struct {
    bit v;
    bit fs;
    int ar, ai, br, bi;
    int dr, di;
    int sr, si;
    int addr;
    bit last;
  } vec_t;

  vec_t vecs [16];
  int   nv;

  bfu_dif_pre #(
    .DWIDTH(16), .NPTS(16), .LOG2_STRIDE(1), .MULT_LAT(6)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .frame_start(frame_start),
    .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
    .tw_rd_en(tw_rd_en), .tw_addr(tw_addr),
    .mult_ar(mult_ar), .mult_ai(mult_ai), .mult_valid(mult_valid),
    .sum_r(sum_r), .sum_i(sum_i), .sum_valid(sum_valid),
    .frame_last(frame_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit v, input bit fs,
                              input int ar, input int ai, input int br, input int bi,
                              input int dr, input int di, input int sr, input int si,
                              input int addr, input bit last);
    vec_t x;
    x.v = v; x.fs = fs;
    x.ar = ar; x.ai = ai; x.br = br; x.bi = bi;
    x.dr = dr; x.di = di; x.sr = sr; x.si = si;
    x.addr = addr; x.last = last;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    in_valid    = x.v;
    frame_start = x.fs;
    a_r = 16'(x.ar); a_i = 16'(x.ai);
    b_r = 16'(x.br); b_i = 16'(x.bi);
  endtask

  task automatic idle();
    in_valid = 1'b0; frame_start = 1'b0;
    a_r = '0; a_i = '0; b_r = '0; b_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".tw_rd_en"},   tw_rd_en,   0);
    check({tag, ".tw_addr"},    tw_addr,    0);
    check({tag, ".mult_ar"},    mult_ar,    0);
    check({tag, ".mult_ai"},    mult_ai,    0);
    check({tag, ".mult_valid"}, mult_valid, 0);
    check({tag, ".sum_r"},      sum_r,      0);
    check({tag, ".sum_i"},      sum_i,      0);
    check({tag, ".sum_valid"},  sum_valid,  0);
    check({tag, ".frame_last"}, frame_last, 0);
  endtask

  task automatic check_no_valid(input string tag);
    check({tag, ".tw_rd_en"},   tw_rd_en,   0);
    check({tag, ".mult_valid"}, mult_valid, 0);
    check({tag, ".sum_valid"},  sum_valid,  0);
    check({tag, ".frame_last"}, frame_last, 0);
  endtask

  // Apply vecs[0..nv-1] one per cycle; check +1 (ROM), +2 (mult), +8 (sum).
  task automatic run_vecs(input string name);
    int j;
    bit ev;
    for (int c = 0; c < nv + 10; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        j = c - 1; ev = 1'b0;
        if (j < nv) ev = vecs[j].v;
        check($sformatf("%s.tw_rd_en[%0d]", name, j), tw_rd_en, ev);
        if (ev) check($sformatf("%s.tw_addr[%0d]", name, j), tw_addr, vecs[j].addr);
      end
      if (c >= 2) begin
        j = c - 2; ev = 1'b0;
        if (j < nv) ev = vecs[j].v;
        check($sformatf("%s.mult_valid[%0d]", name, j), mult_valid, ev);
        if (ev) begin
          check($sformatf("%s.mult_ar[%0d]", name, j), mult_ar, vecs[j].dr);
          check($sformatf("%s.mult_ai[%0d]", name, j), mult_ai, vecs[j].di);
        end
      end
      if (c >= 8) begin
        j = c - 8; ev = 1'b0;
        if (j < nv) ev = vecs[j].v;
        check($sformatf("%s.sum_valid[%0d]", name, j), sum_valid, ev);
        check($sformatf("%s.frame_last[%0d]", name, j), frame_last,
              (ev && vecs[j].last) ? 1 : 0);
        if (ev) begin
          check($sformatf("%s.sum_r[%0d]", name, j), sum_r, vecs[j].sr);
          check($sformatf("%s.sum_i[%0d]", name, j), sum_i, vecs[j].si);
        end
      end
      if (c < nv) drive(vecs[c]);
      else        idle();
    end
  endtask

  initial begin
    // Reset held with live random inputs: everything stays 0.
    reset_n = 1'b0;
    in_valid = 1'b1; frame_start = 1'b1;
    a_r = 16'($urandom); a_i = 16'($urandom);
    b_r = 16'($urandom); b_i = 16'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    idle();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_no_valid($sformatf("post_reset%0d", c));
    end

    // Single sample.
    nv = 1;
    vecs[0] = mk(1, 1, 100, -50, 30, 20, 70, -70, 130, -30, 0, 0);
    run_vecs("single");

    // Extremes: no wrap in 17 bits.
    nv = 1;
    vecs[0] = mk(1, 1, 32767, -32768, -32768, 32767, 65535, -65535, -1, -1, 0, 0);
    run_vecs("extreme");

    // Bubbles, ignored frame_start on a bubble, restart on a valid sample.
    // k is 1 on entry (previous sample started a frame).
    nv = 5;
    vecs[0] = mk(1, 0,    5,     6,     1,    2,    4,     4,  6,  8, 2, 0);
    vecs[1] = mk(0, 1,  999,   999,   999,  999,    0,     0,  0,  0, 0, 0);
    vecs[2] = mk(1, 0,   -7,     3,     2,   -9,   -9,    12, -5, -6, 4, 0);
    vecs[3] = mk(1, 1, 1000, -1000, -1000, 1000, 2000, -2000,  0,  0, 0, 0);
    vecs[4] = mk(1, 0,    0,     1,     1,    0,   -1,     1,  1,  1, 2, 0);
    run_vecs("bubble");

    // Full frame of 8 plus one wrapped sample: a=(100j,3j), b=(10j,-7j).
    nv = 9;
    vecs[0] = mk(1, 1,   0,  0,  0,   0,   0,  0,   0,   0, 0, 0);
    vecs[1] = mk(1, 0, 100,  3, 10,  -7,  90, 10, 110,  -4, 2, 0);
    vecs[2] = mk(1, 0, 200,  6, 20, -14, 180, 20, 220,  -8, 4, 0);
    vecs[3] = mk(1, 0, 300,  9, 30, -21, 270, 30, 330, -12, 6, 0);
    vecs[4] = mk(1, 0, 400, 12, 40, -28, 360, 40, 440, -16, 0, 0);
    vecs[5] = mk(1, 0, 500, 15, 50, -35, 450, 50, 550, -20, 2, 0);
    vecs[6] = mk(1, 0, 600, 18, 60, -42, 540, 60, 660, -24, 4, 0);
    vecs[7] = mk(1, 0, 700, 21, 70, -49, 630, 70, 770, -28, 6, 1);
    vecs[8] = mk(1, 0, 800, 24, 80, -56, 720, 80, 880, -32, 0, 0);
    run_vecs("frame");

    // Reset mid-stream; k is 1 on entry so the burst starts at address 2.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      drive(mk(1, 0, 10 + s, 20, s, 5, 0, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    check("midrst.pre_tw_rd_en",   tw_rd_en,   1);
    check("midrst.pre_tw_addr",    tw_addr,    6);
    check("midrst.pre_mult_valid", mult_valid, 1);
    check("midrst.pre_mult_ar",    mult_ar,    10);
    drive(mk(1, 0, 13, 20, 3, 5, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    idle();
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_no_valid($sformatf("midrst_after%0d", c));
    end
    drive(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    idle();
    check("midrst.next_tw_rd_en", tw_rd_en, 1);
    check("midrst.next_tw_addr",  tw_addr,  0);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
